operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
//  Stage directly upstream of the ALU: holds the 32x32 integer register file and reads rs1/rs2.
//  Selects operand B as either rs2 or the immediate.
//  Registers {A, B, Upr_ALU, rd} into one pipeline slot with valid/ready handshake.
//  Consumer is the ALU plus the writeback path.
// PARAMETERS
//  XLEN   32  data width of registers and operands
//  NREG   32  number of architectural registers (addr width = $clog2(NREG))
//  OP_W   5   width of Upr_ALU control code
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  rst_n        in   1     reset, synchronous, active-low
//  in_valid     in   1     decoded instruction present
//  in_ready     out  1     stage can accept instruction this cycle
//  rs1_addr     in   5     source register 1 index
//  rs2_addr     in   5     source register 2 index
//  imm          in   XLEN  sign-extended immediate from decoder
//  b_sel        in   1     0: B=rs2 value, 1: B=imm
//  upr_in       in   OP_W  ALU control code from decoder
//  rd_in        in   5     destination index, passed through
//  flush        in   1     kill held instruction (branch taken)
//  wb_en        in   1     register-file write enable
//  wb_addr      in   5     write index
//  wb_data      in   XLEN  write data
//  out_valid    out  1     A/B/Upr_ALU valid toward ALU
//  out_ready    in   1     downstream accepts this cycle
//  A            out  XLEN  operand A (registered)
//  B            out  XLEN  operand B (registered)
//  Upr_ALU      out  OP_W  ALU control (registered)
//  rd_out       out  5     destination index (registered)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): out_valid=0, A=B=0, Upr_ALU=0 (ADD), rd_out=0, all regs x1..x31=0.
//  Register file: async read, sync write at edge when wb_en && wb_addr!=0; writes to x0 dropped.
//  Reads of x0 return 0 always.
//  in_ready = !out_valid || out_ready (combinational; single-slot pipeline, no skid buffer).
//  load = in_valid && in_ready && !flush; on load capture A=rf[rs1], B=b_sel?imm:rf[rs2],
//   Upr_ALU=upr_in, rd_out=rd_in; out_valid<=1. Latency: 1 cycle in->out.
//  Priority at edge: reset > flush > load > drain.
//  Flush: out_valid<=0; incoming instruction the same cycle is discarded.
//  Drain: out_valid && out_ready && !load -> out_valid<=0; data regs hold last value.
//  Stall: out_valid && !out_ready -> all output regs hold, in_ready=0.
//  Simultaneous accept+emit: out_ready=1 with in_valid=1 -> back-to-back, out_valid stays 1.
//  Register-file write is independent of handshake and flush; it happens even in stall/flush cycles.
//  Reset mid-operation: held instruction lost, register contents cleared.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: if wb_en && wb_addr!=0 && wb_addr==rsN_addr, read returns wb_data
//   in the same cycle (write-through).
//  Not defined: same-cycle read returns the old value; the hazard is handled by the caller.
// STRUCTURE
//  alu_pkg: XLEN, OP_W, Upr_ALU codes (ADD 00000 ... GEU 11111), REG_ADDR_W=5.
//  Sub-module reg_file_2r1w (2 async read, 1 sync write, x0 hardwired, bypass under macro).
//  Pipeline register + handshake logic in this module.
// TESTING
//  Reset, then wb x5=0x0000_00AA, x6=0x0000_0055; issue rs1=5 rs2=6 b_sel=0 upr=ADD
//   -> next cycle out_valid=1, A=0xAA, B=0x55, Upr_ALU=00000.
//  wb_en addr 0 data 0xFFFF_FFFF, then read rs1=0 -> A=0.
//  b_sel=1 imm=0xFFFF_FFF0 -> B=0xFFFF_FFF0 regardless of rs2.
//  out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, A/B stable.
//  Release -> one transfer per cycle, no loss/duplication over 8 instrs.
//  flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0, new instr not captured.
//  wb x7=0x1234 same cycle as read rs1=7 (x7 old=0) -> A=0x1234 with REGFILE_BYPASS_EN,
//   A=0 without.
//  rst_n=0 during stall -> out_valid=0, A=0, x5 reads 0 afterward.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths and ALU control codes for the operand fetch / execute slice.
package alu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREG       = 32;
    localparam int unsigned OP_W       = 5;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b00001,
        ALU_SLL  = 5'b00010,
        ALU_SLT  = 5'b00011,
        ALU_SLTU = 5'b00100,
        ALU_XOR  = 5'b00101,
        ALU_SRL  = 5'b00110,
        ALU_SRA  = 5'b00111,
        ALU_OR   = 5'b01000,
        ALU_AND  = 5'b01001,
        ALU_EQ   = 5'b11010,
        ALU_NE   = 5'b11011,
        ALU_LT   = 5'b11100,
        ALU_GE   = 5'b11101,
        ALU_LTU  = 5'b11110,
        ALU_GEU  = 5'b11111
    } alu_op_e;

endpackage

// File: rtl/reg_file_2r1w.sv
// Integer register file: two async read ports, one sync write port, x0 hardwired to zero.
// REGFILE_BYPASS_EN: same-cycle write data is forwarded to matching read ports.
module reg_file_2r1w
    import alu_pkg::*;
#(
    parameter int unsigned XLEN_P = XLEN,
    parameter int unsigned NREG_P = NREG,
    parameter int unsigned AW     = $clog2(NREG_P)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN_P-1:0] rs1_data,
    output logic [XLEN_P-1:0] rs2_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN_P-1:0] wb_data
);

    logic [XLEN_P-1:0] regs [NREG_P];
    logic              wr_fire;

    assign wr_fire = wb_en && (wb_addr != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG_P; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_fire) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_fire && (wb_addr == rs1_addr)) rs1_data = wb_data;
        if (wr_fire && (wb_addr == rs2_addr)) rs2_data = wb_data;
`endif
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: register file read, operand B mux, single-slot valid/ready pipeline register.
// REGFILE_BYPASS_EN selects write-through reads in the register file.
module operand_fetch_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN_P = XLEN,
    parameter int unsigned NREG_P = NREG,
    parameter int unsigned OP_W_P = OP_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [XLEN_P-1:0]     imm,
    input  logic                  b_sel,
    input  logic [OP_W_P-1:0]     upr_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  flush,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN_P-1:0]     wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN_P-1:0]     A,
    output logic [XLEN_P-1:0]     B,
    output logic [OP_W_P-1:0]     Upr_ALU,
    output logic [REG_ADDR_W-1:0] rd_out
);

    logic [XLEN_P-1:0] rs1_data;
    logic [XLEN_P-1:0] rs2_data;
    logic              load;

    reg_file_2r1w #(
        .XLEN_P (XLEN_P),
        .NREG_P (NREG_P),
        .AW     (REG_ADDR_W)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // Data registers only move on load; drain and flush clear valid alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            A         <= '0;
            B         <= '0;
            Upr_ALU   <= '0;
            rd_out    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            A         <= rs1_data;
            B         <= b_sel ? imm : rs2_data;
            Upr_ALU   <= upr_in;
            rd_out    <= rd_in;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed self-checking bench for operand_fetch_stage; honours REGFILE_BYPASS_EN for the hazard case.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] imm;
    logic        b_sel;
    logic [4:0]  upr_in;
    logic [4:0]  rd_in;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  Upr_ALU;
    logic [4:0]  rd_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .imm       (imm),
        .b_sel     (b_sel),
        .upr_in    (upr_in),
        .rd_in     (rd_in),
        .flush     (flush),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A),
        .B         (B),
        .Upr_ALU   (Upr_ALU),
        .rd_out    (rd_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic bs,
                         input logic [31:0] im, input logic [4:0] op, input logic [4:0] rd);
        in_valid = 1'b1;
        rs1_addr = r1;
        rs2_addr = r2;
        b_sel    = bs;
        imm      = im;
        upr_in   = op;
        rd_in    = rd;
    endtask

    logic [31:0] exp_bypass;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; rs1_addr = '0; rs2_addr = '0; imm = '0;
        b_sel = 1'b0; upr_in = '0; rd_in = '0; flush = 1'b0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        step(); step();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_A", A, 32'd0);
        check("rst_B", B, 32'd0);
        check("rst_upr", {27'd0, Upr_ALU}, 32'd0);
        check("rst_rd", {27'd0, rd_out}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_00AA; step();
        wb_addr = 5'd6; wb_data = 32'h0000_0055; step();
        wb_en = 1'b0;

        issue(5'd5, 5'd6, 1'b0, 32'd0, 5'b00000, 5'd3); step();
        check("basic_valid", {31'd0, out_valid}, 32'd1);
        check("basic_A", A, 32'h0000_00AA);
        check("basic_B", B, 32'h0000_0055);
        check("basic_upr", {27'd0, Upr_ALU}, 32'd0);
        check("basic_rd", {27'd0, rd_out}, 32'd3);
        in_valid = 1'b0; step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_A_hold", A, 32'h0000_00AA);

        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF; step();
        wb_en = 1'b0;
        issue(5'd0, 5'd5, 1'b1, 32'hFFFF_FFF0, 5'b00001, 5'd4); step();
        check("x0_A", A, 32'd0);
        check("imm_B", B, 32'hFFFF_FFF0);
        check("imm_upr", {27'd0, Upr_ALU}, 32'd1);
        check("imm_rd", {27'd0, rd_out}, 32'd4);
        in_valid = 1'b0; step();

        out_ready = 1'b0;
        issue(5'd6, 5'd5, 1'b0, 32'd0, 5'b00010, 5'd7); step();
        check("stall_load_A", A, 32'h0000_0055);
        check("stall_load_B", B, 32'h0000_00AA);
        issue(5'd5, 5'd5, 1'b1, 32'd1, 5'b00011, 5'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_A", A, 32'h0000_0055);
            check("stall_B", B, 32'h0000_00AA);
            check("stall_rd", {27'd0, rd_out}, 32'd7);
        end

        out_ready = 1'b1; #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            issue(5'd5, 5'd6, 1'b1, k, 5'b00011, k[4:0]);
            step();
            check("b2b_valid", {31'd0, out_valid}, 32'd1);
            check("b2b_B", B, k);
            check("b2b_rd", {27'd0, rd_out}, k);
        end

        flush = 1'b1;
        issue(5'd6, 5'd6, 1'b1, 32'h99, 5'b00100, 5'd9); step();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0; step();
        check("flush_valid2", {31'd0, out_valid}, 32'd0);
        check("flush_B_hold", B, 32'd8);
        check("flush_rd_hold", {27'd0, rd_out}, 32'd8);

`ifdef REGFILE_BYPASS_EN
        exp_bypass = 32'h0000_1234;
`else
        exp_bypass = 32'h0000_0000;
`endif
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_1234;
        issue(5'd7, 5'd0, 1'b1, 32'd0, 5'b00000, 5'd1); step();
        check("hazard_A", A, exp_bypass);
        wb_en = 1'b0; step();
        check("after_wb_A", A, 32'h0000_1234);
        in_valid = 1'b0; step();

        out_ready = 1'b0;
        issue(5'd5, 5'd6, 1'b0, 32'd0, 5'b00000, 5'd2); step();
        check("pre_rst_A", A, 32'h0000_00AA);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0; step();
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_A", A, 32'd0);
        rst_n = 1'b1; out_ready = 1'b1; step();
        check("post_rst_x5", A, 32'd0);
        check("post_rst_x6", B, 32'd0);
        in_valid = 1'b0; step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
